// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: class/function codes and FSM state type shared by the alu_mc slice.
package alu_mc_pkg;
    localparam logic [1:0] FC_A = 2'b00;
    localparam logic [1:0] FC_B = 2'b01;
    localparam logic [1:0] FC_C = 2'b10;
    localparam logic [3:0] ADD = 4'b0000;
    localparam logic [3:0] SUB = 4'b0001;
    localparam logic [3:0] AND = 4'b0010;
    localparam logic [3:0] OR  = 4'b0011;
    localparam logic [3:0] MUL = 4'b0100;
    localparam logic [3:0] DIV = 4'b0101;
    localparam logic [3:0] SHL = 4'b1000;
    localparam logic [3:0] SHR = 4'b1001;
    localparam logic [3:0] LW  = 4'b0000;
    localparam logic [3:0] SW  = 4'b0001;
    localparam logic [3:0] BLT = 4'b0000;
    localparam logic [3:0] BGT = 4'b0001;
    localparam logic [3:0] BEQ = 4'b0010;
    localparam logic [3:0] JMP = 4'b0011;
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
endpackage

// File: rtl/alu_mc_if.sv
// alu_mc_if: operation request / result handshake bundle of the EX-stage ALU.
interface alu_mc_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_fc;
    logic [3:0]       func_c;
    logic [WIDTH-1:0] in1_m2;
    logic [WIDTH-1:0] in2_m7;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] op;
    logic [WIDTH-1:0] out_r0;
    logic             out_flag;
    logic             out_oflw;
    logic             out_illegal;
    logic             busy;
    modport master (
        output in_valid, in_fc, func_c, in1_m2, in2_m7, out_ready,
        input  in_ready, out_valid, op, out_r0, out_flag, out_oflw, out_illegal, busy
    );
    modport slave (
        input  in_valid, in_fc, func_c, in1_m2, in2_m7, out_ready,
        output in_ready, out_valid, op, out_r0, out_flag, out_oflw, out_illegal, busy
    );
endinterface

// File: rtl/alu_mc_muldiv.sv
// alu_mc_muldiv: shared shift-add multiplier / restoring divider on operand magnitudes.
// Results are combinational off the final step so done and the result coincide.
module alu_mc_muldiv
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             abort,
    input  logic             start,
    input  logic             div_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             oflw
);
    localparam int CW = $clog2(WIDTH);
    logic [2*WIDTH:0]   acc, acc_nx;
    logic [WIDTH-1:0]   mb, a_keep, qm, rm;
    logic [WIDTH:0]     hi_sum, shifted;
    logic [2*WIDTH-1:0] pm, prod;
    logic [CW-1:0]      cnt;
    logic               run, is_div, sa, sb, dz, mn;
    // acc holds {hi, lo}: product accumulator / multiplier for mul, remainder / quotient for div
    always_comb begin
        hi_sum  = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, mb} : '0);
        shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        acc_nx  = !is_div ? {1'b0, hi_sum, acc[WIDTH-1:1]} :
                  (shifted >= {1'b0, mb}) ? {shifted - {1'b0, mb}, acc[WIDTH-2:0], 1'b1} :
                  {shifted, acc[WIDTH-2:0], 1'b0};
        pm      = acc_nx[2*WIDTH-1:0];
        prod    = (sa ^ sb) ? -pm : pm;
        qm      = acc_nx[WIDTH-1:0];
        rm      = acc_nx[2*WIDTH-1:WIDTH];
        q       = dz ? '1 : is_div ? ((sa ^ sb) ? -qm : qm) : prod[WIDTH-1:0];
        r       = dz ? a_keep : is_div ? (sa ? -rm : rm) : prod[2*WIDTH-1:WIDTH];
        oflw    = is_div ? (dz | mn) : (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
        done    = run & (cnt == CW'(WIDTH - 1));
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mb     <= '0;
            a_keep <= '0;
            cnt    <= '0;
            run    <= 1'b0;
            is_div <= 1'b0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            dz     <= 1'b0;
            mn     <= 1'b0;
        end else begin
            run <= start | (run & !done & !abort);
            if (start) begin
                acc    <= {{(WIDTH+1){1'b0}}, a[WIDTH-1] ? -a : a};
                mb     <= b[WIDTH-1] ? -b : b;
                a_keep <= a;
                cnt    <= '0;
                is_div <= div_mode;
                sa     <= a[WIDTH-1];
                sb     <= b[WIDTH-1];
                dz     <= div_mode & (b == '0);
                mn     <= (a == {1'b1, {(WIDTH-1){1'b0}}}) & (&b);
            end else if (run) begin
                acc <= acc_nx;
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: registered EX-stage ALU with valid/ready handshake, flush and iterative mul/div.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    alu_mc_if.slave   bus
);
    state_t           state, state_nx;
    logic [WIDTH-1:0] a, b, sum, dif, res, md_q, md_r;
    logic             accept, is_md, res_flag, res_oflw, res_ill, md_done, md_oflw;
    assign a = bus.in1_m2;
    assign b = bus.in2_m7;
    always_comb begin
        sum      = a + b;
        dif      = a - b;
        res      = '0;
        res_flag = 1'b0;
        res_oflw = 1'b0;
        res_ill  = 1'b0;
        is_md    = 1'b0;
        case (bus.in_fc)
            FC_A: case (bus.func_c)
                ADD:      begin res = sum; res_oflw = (a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]); end
                SUB:      begin res = dif; res_oflw = (a[WIDTH-1] != b[WIDTH-1]) & (dif[WIDTH-1] != a[WIDTH-1]); end
                AND:      res = a & b;
                OR:       res = a | b;
                MUL, DIV: is_md = 1'b1;
                SHL:      res = a << b;
                SHR:      res = a >> b;
                default:  res_ill = 1'b1;
            endcase
            FC_B: case (bus.func_c)
                LW, SW:  res = sum;
                default: res_ill = 1'b1;
            endcase
            FC_C: case (bus.func_c)
                BLT:     res_flag = $signed(a) < $signed(b);
                BGT:     res_flag = $signed(a) > $signed(b);
                BEQ:     res_flag = a == b;
                JMP:     res_flag = 1'b1;
                default: res_ill = 1'b1;
            endcase
            default: res_ill = 1'b1;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        bus.in_ready = !flush & ((state == S_IDLE) | ((state == S_DONE) & bus.out_ready));
        accept       = bus.in_valid & bus.in_ready;
        state_nx     = flush ? S_IDLE :
                       accept ? (!is_md ? S_DONE : (bus.func_c == MUL) ? S_MUL : S_DIV) :
                       ((state == S_DONE) & bus.out_ready) ? S_IDLE :
                       md_done ? S_DONE : state;
    end
    assign bus.out_valid = state == S_DONE;
    assign bus.busy      = (state == S_MUL) | (state == S_DIV);
    alu_mc_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .abort    (flush),
        .start    (accept & is_md),
        .div_mode (bus.func_c == DIV),
        .a        (a),
        .b        (b),
        .done     (md_done),
        .q        (md_q),
        .r        (md_r),
        .oflw     (md_oflw)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {bus.op, bus.out_r0, bus.out_flag, bus.out_oflw, bus.out_illegal} <= '0;
        end else if (flush) begin
            {bus.op, bus.out_r0, bus.out_flag, bus.out_oflw, bus.out_illegal} <= '0;
        end else if (accept) begin
            {bus.op, bus.out_r0, bus.out_flag, bus.out_oflw, bus.out_illegal} <= {res, {WIDTH{1'b0}}, res_flag, res_oflw, res_ill};
        end else if (md_done) begin
            {bus.op, bus.out_r0, bus.out_flag, bus.out_oflw, bus.out_illegal} <= {md_q, md_r, 1'b0, md_oflw, 1'b0};
        end
    end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, registered successor to the combinational ALU; sits in the EX stage between operand-forward muxes and the EX/MEM register.
- Covers the A, B and C instruction classes:
  - A type: arithmetic and logic.
  - B type: lw/sw address calculation.
  - C type: branch compare and jump.
- Adds a valid/ready handshake, two's-complement signed semantics at any WIDTH, iterative multi-cycle multiply/divide, flush, and fully defined flags.

Parameters:
- WIDTH, 16, datapath width in bits (>=4).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort of the in-flight op (pipeline flush on taken branch).
- in_valid  in  1  operation presented.
- in_ready  out  1  block can accept an operation this cycle.
- in_fc  in  2  class: 00 A type, 01 B type, 10 C type, 11 reserved.
- func_c  in  4  function within class.
- in1_m2  in  WIDTH  operand A.
- in2_m7  in  WIDTH  operand B.
- out_valid  out  1  result held on outputs.
- out_ready  in  1  consumer accepts the result.
- op  out  WIDTH  primary result.
- out_r0  out  WIDTH  secondary result: multiply high half or divide remainder; 0 otherwise.
- out_flag  out  1  branch/jump taken.
- out_oflw  out  1  overflow or divide-by-zero.
- out_illegal  out  1  unsupported in_fc/func_c combination.
- busy  out  1  multiply/divide iterating.

Behaviour:
- Reset: state IDLE. op, out_r0, out_flag, out_oflw, out_illegal, out_valid and busy are all 0; in_ready is 1 after reset.
- FSM states: IDLE, MUL, DIV, DONE.
  - in_ready = (state==IDLE) | (state==DONE & out_ready).
  - Accept = in_valid & in_ready.
- Single-cycle ops (everything except mul/div): on accept, the result is registered and the FSM enters DONE; out_valid rises the next cycle (latency 1).
  - Back-to-back accepts from DONE give a throughput of 1 per cycle.
- mul (A/0100) and div (A/0101): on accept, enter MUL/DIV with busy=1.
  - The unit iterates on operand magnitudes for exactly WIDTH cycles, one bit per cycle, then enters DONE. out_valid is asserted WIDTH+1 cycles after the accept.
  - mul: op = low WIDTH bits of the 2*WIDTH signed product; out_r0 = high bits. out_oflw = 1 iff the high half is not the sign extension of op.
  - div: op = quotient truncated toward zero; out_r0 = remainder with the sign of the dividend.
  - div by zero: op = all ones, out_r0 = dividend, out_oflw = 1, and the op still takes the full WIDTH+1 latency.
  - Most-negative / -1: op = most-negative, out_r0 = 0, out_oflw = 1.
- DONE: outputs stay stable while out_valid & !out_ready. On handshake, go to IDLE, or re-enter per a simultaneous accept.
- A type functions:
  - 0000 add, with signed overflow: operands share a sign and the result differs.
  - 0001 sub, with signed overflow.
  - 0010 and, 0011 or.
  - 1000 shl, 1001 logical shr. Shift amount = in2_m7 unsigned; an amount >= WIDTH gives 0. Flag and oflw are 0.
- B type functions: 0000 lw and 0001 sw both give op = A+B modulo 2^WIDTH, with oflw = 0.
- C type functions: 0000 signed A<B, 0001 signed A>B, 0010 A==B, 0011 jump (flag=1 unconditionally).
  - op = 0 and oflw = 0. out_flag = 0 when the branch is not taken; no value is held over from a previous op.
- Any other combination: out_illegal = 1, all other results 0, latency 1.
- flush: highest priority over accept and handshake.
  - Forces the FSM to IDLE and clears out_valid and busy. Output data registers are cleared to 0.
  - in_ready is 0 in the flush cycle, so no accept occurs.
- Operands are captured at accept. Input changes during MUL/DIV have no effect.
- Async reset mid-iteration returns to the reset values immediately.

Decomposition:
- Package alu_mc_pkg holds:
  - class localparams FC_A, FC_B, FC_C;
  - func codes ADD, SUB, AND, OR, MUL, DIV, SHL, SHR, LW, SW, BLT, BGT, BEQ, JMP;
  - the state enum.
- One sub-module, alu_mc_muldiv: shared shift-add multiplier / restoring divider on magnitudes, with start/done, sign fix-up and the special cases.
- Remaining logic lives in the top: FSM, handshake, single-cycle datapath and output registers.

Test Plan:
- Add 0x7FFF+0x0001 with out_ready=1 -> next cycle out_valid=1, op=0x8000, out_oflw=1, out_flag=0.
- Mul 300 × -200 -> out_valid exactly 17 cycles after accept, busy high 16 cycles; op=0x15A0, out_r0=0xFFFF, out_oflw=1.
- Div -7 / 2 -> op=0xFFFD, out_r0=0xFFFF, oflw=0. Div 5 / 0 -> op=0xFFFF, out_r0=0x0005, oflw=1.
- Branch sequence:
  - BLT -1,1 -> flag=1.
  - Then BEQ 3,4 back-to-back -> flag=0.
  - Then in_fc=11 -> out_illegal=1.
  - One result per cycle with out_ready held 1.
- Backpressure: out_ready=0 for 5 cycles after an OR result -> op/flags stable, in_ready=0. Raising out_ready with a new in_valid gives a same-cycle accept.
- flush at iteration 8 of a div -> next cycle IDLE, out_valid=0, busy=0, in_ready=1. An rst_n pulse during mul gives reset values immediately.
